// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : CPU memory responder. It contains a cleared-on-reset RAM, an I/O
//            page (button flags and levels, LED register, optional timer) and
//            returns read data one cycle after the address is presented.
// Options  : MEM_RESPONDER_TIMER_EN adds the free-running TIMER at IO_BASE+3
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_BITS = 10,
    parameter logic [WIDTH-1:0] IO_BASE   = 16'hFF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] mem_address,
    input  logic [WIDTH-1:0] data_to_mem_store,
    input  logic             write_to_memory,
    input  logic             reading_for_load,
    input  logic             left,
    input  logic             right,
    input  logic             start,
    output logic [WIDTH-1:0] data_from_mem,
    output logic [WIDTH-1:0] led_out,
    output logic             mem_ready
);

    localparam int                   c_depth    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] c_clr_last = '1;
    localparam logic [1:0]           c_sel_zero = 2'd0;
    localparam logic [1:0]           c_sel_ram  = 2'd1;
    localparam logic [1:0]           c_sel_io   = 2'd2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_clr_cnt;
    logic [WIDTH-1:0]     r_mem [c_depth];
    logic [WIDTH-1:0]     r_ram_rd;
    logic [WIDTH-1:0]     r_io_rd;
    logic [WIDTH-1:0]     r_led;
    logic [1:0]           r_rd_sel;
    logic                 r_ready;
    logic [2:0]           r_sync1;
    logic [2:0]           r_sync2;
    logic [2:0]           r_prev;
    logic [2:0]           r_flags;

    logic                 w_run;
    logic                 w_is_ram;
    logic                 w_is_io;
    logic [WIDTH-1:0]     w_io_off;
    logic [1:0]           w_io_idx;
    logic [2:0]           w_edge;
    logic                 w_flag_clr;
    logic [WIDTH-1:0]     w_io_rdata;
    logic                 w_ram_we;
    logic [ADDR_BITS-1:0] w_ram_waddr;
    logic [WIDTH-1:0]     w_ram_wdata;

    assign w_run    = (r_state == ST_RUN);
    assign w_is_ram = ((mem_address >> ADDR_BITS) == '0);
    assign w_io_off = mem_address - IO_BASE;
    assign w_is_io  = (mem_address >= IO_BASE) && (w_io_off[WIDTH-1:2] == '0);
    assign w_io_idx = w_io_off[1:0];
    assign w_edge   = r_sync2 & ~r_prev;

    // Only a load-qualified read clears flags; fetches and plain reads must not.
    assign w_flag_clr = w_run && reading_for_load && w_is_io && (w_io_idx == 2'd0);

`ifdef MEM_RESPONDER_TIMER_EN
    logic [WIDTH-1:0] r_timer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (!w_run) begin
            r_timer <= '0;
        end else if (write_to_memory && w_is_io && (w_io_idx == 2'd3)) begin
            r_timer <= data_to_mem_store;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`endif

    always_comb begin
        w_io_rdata = '0;
        case (w_io_idx)
            2'd0: w_io_rdata[2:0] = r_flags;
            2'd1: w_io_rdata[2:0] = r_sync2;
            2'd2: w_io_rdata      = r_led;
`ifdef MEM_RESPONDER_TIMER_EN
            2'd3: w_io_rdata      = r_timer;
`endif
            default: w_io_rdata   = '0;
        endcase
    end

    // The clear FSM owns the single write port until the RAM is zeroed.
    always_comb begin
        w_ram_we    = write_to_memory && w_is_ram;
        w_ram_waddr = mem_address[ADDR_BITS-1:0];
        w_ram_wdata = data_to_mem_store;
        if (!w_run) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_clr_cnt;
            w_ram_wdata = '0;
        end
    end

    // Read-before-write falls out of the non-blocking read of the old word.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_waddr] <= w_ram_wdata;
        end
        r_ram_rd <= r_mem[mem_address[ADDR_BITS-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
            r_rd_sel  <= c_sel_zero;
            r_io_rd   <= '0;
            r_led     <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_flags   <= '0;
        end else begin
            r_sync1 <= {start, right, left};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // A new edge in the clearing cycle survives the clear.
            if (w_flag_clr) begin
                r_flags <= w_edge;
            end else begin
                r_flags <= r_flags | w_edge;
            end

            case (r_state)
                ST_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    r_rd_sel  <= c_sel_zero;
                    if (r_clr_cnt == c_clr_last) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                    r_io_rd <= w_io_rdata;
                    if (w_is_ram) begin
                        r_rd_sel <= c_sel_ram;
                    end else if (w_is_io) begin
                        r_rd_sel <= c_sel_io;
                    end else begin
                        r_rd_sel <= c_sel_zero;
                    end
                    if (write_to_memory && w_is_io && (w_io_idx == 2'd2)) begin
                        r_led <= data_to_mem_store;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        case (r_rd_sel)
            c_sel_ram: data_from_mem = r_ram_rd;
            c_sel_io:  data_from_mem = r_io_rd;
            default:   data_from_mem = '0;
        endcase
    end

    assign led_out   = r_led;
    assign mem_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder (vector table + scoreboard)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_address = '0;
    logic [15:0] data_to_mem_store = '0;
    logic        write_to_memory = 1'b0;
    logic        reading_for_load = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_from_mem;
    logic [15:0] led_out;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    mem_responder dut (
        .clk               (clk),
        .reset             (reset),
        .mem_address       (mem_address),
        .data_to_mem_store (data_to_mem_store),
        .write_to_memory   (write_to_memory),
        .reading_for_load  (reading_for_load),
        .left              (left),
        .right             (right),
        .start             (start),
        .data_from_mem     (data_from_mem),
        .led_out           (led_out),
        .mem_ready         (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [15:0] data;
        logic        chk_led;
        logic [15:0] led;
        string       name;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic        rd;
        logic [15:0] exp_data;
        logic [15:0] exp_led;
    } vec_t;

    localparam int c_nvec = 23;
    vec_t vecs [c_nvec];
    exp_t sb [$];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one request, push its expectation, pop and compare after the edge.
    task automatic req(input logic [15:0] a, input logic [15:0] wd, input logic we,
                       input logic rd, input logic chk, input logic [15:0] exp,
                       input logic chk_led, input logic [15:0] exp_led, input string nm);
        exp_t e;
        @(negedge clk);
        mem_address       = a;
        data_to_mem_store = wd;
        write_to_memory   = we;
        reading_for_load  = rd;
        sb.push_back('{chk, exp, chk_led, exp_led, nm});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk)     check({e.name, "_data"}, data_from_mem, e.data);
        if (e.chk_led) check({e.name, "_led"}, led_out, e.led);
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!mem_ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (!mem_ready) check({nm, "_init_data"}, data_from_mem, 16'h0000);
            if (n > 2) n_cmp--;
        end
        check({nm, "_init_cycles"}, 16'(n), 16'd1024);
        check({nm, "_ready"}, {15'd0, mem_ready}, 16'd1);
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] wd, input logic we,
                                input logic [15:0] ed, input logic [15:0] el);
        vec_t v;
        v.addr = a; v.wdata = wd; v.we = we; v.rd = ~we; v.exp_data = ed; v.exp_led = el;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1ms", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        vecs[1]  = mk(16'h01FF, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        vecs[2]  = mk(16'h03FF, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        vecs[3]  = mk(16'h0005, 16'hBEEF, 1'b1, 16'h0000, 16'h0000);
        vecs[4]  = mk(16'h0005, 16'h0000, 1'b0, 16'hBEEF, 16'h0000);
        vecs[5]  = mk(16'h0800, 16'h1234, 1'b1, 16'h0000, 16'h0000);
        vecs[6]  = mk(16'h0800, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        vecs[7]  = mk(16'h0007, 16'hAAAA, 1'b1, 16'h0000, 16'h0000);
        vecs[8]  = mk(16'h0007, 16'h5555, 1'b1, 16'hAAAA, 16'h0000);
        vecs[9]  = mk(16'h0007, 16'h0000, 1'b0, 16'h5555, 16'h0000);
        vecs[10] = mk(16'hFF02, 16'h00A5, 1'b1, 16'h0000, 16'h00A5);
        vecs[11] = mk(16'hFF02, 16'h0000, 1'b0, 16'h00A5, 16'h00A5);
        vecs[12] = mk(16'hFF00, 16'hFFFF, 1'b1, 16'h0000, 16'h00A5);
        vecs[13] = mk(16'hFF00, 16'h0000, 1'b0, 16'h0000, 16'h00A5);
        vecs[14] = mk(16'hFF01, 16'hFFFF, 1'b1, 16'h0000, 16'h00A5);
        vecs[15] = mk(16'hFF01, 16'h0000, 1'b0, 16'h0000, 16'h00A5);
        vecs[16] = mk(16'hFF04, 16'h0000, 1'b0, 16'h0000, 16'h00A5);
        vecs[17] = mk(16'hFF10, 16'h1111, 1'b1, 16'h0000, 16'h00A5);
        vecs[18] = mk(16'hFF10, 16'h0000, 1'b0, 16'h0000, 16'h00A5);
        vecs[19] = mk(16'h03FF, 16'hCAFE, 1'b1, 16'h0000, 16'h00A5);
        vecs[20] = mk(16'h03FF, 16'h0000, 1'b0, 16'hCAFE, 16'h00A5);
        vecs[21] = mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h00A5);
        vecs[22] = mk(16'h0005, 16'h0000, 1'b0, 16'hBEEF, 16'h00A5);

        // Reset state
        #1;
        check("rst_data", data_from_mem, 16'h0000);
        check("rst_led", led_out, 16'h0000);
        check("rst_ready", {15'd0, mem_ready}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_ready("boot");

        for (int i = 0; i < c_nvec; i++) begin
            req(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rd,
                1'b1, vecs[i].exp_data, 1'b1, vecs[i].exp_led, $sformatf("vec%0d", i));
        end

        // left held: flag set on the 3rd edge, visible on the 4th read
        left = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, (i >= 4) ? 16'h0001 : 16'h0000,
                1'b0, 16'h0, $sformatf("left_edge%0d", i));
        end
        req(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0, "levels_left");
        req(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, "flags_clr_read");
        req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0, "flags_after_clr_held");
        left = 1'b0;
        for (int i = 0; i < 4; i++) req(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "idle");
        req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0, "flags_no_reset_on_fall");

        // Retain on non-load read
        right = 1'b1;
        for (int i = 0; i < 4; i++) req(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "idle");
        right = 1'b0;
        req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0, "right_fetch_read");
        req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0, "right_retained");
        req(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0, "right_clr_read");
        req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0, "right_cleared");

        // start edge lands on the clearing edge: set wins over clear
        start = 1'b1;
        req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0, "start_e1");
        req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0, "start_e2");
        req(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, "start_clr_same_edge");
        req(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0, "start_survives_clr");
        req(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0, "levels_start");
        start = 1'b0;

`ifdef MEM_RESPONDER_TIMER_EN
        req(16'hFF03, 16'hFFFE, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "timer_load");
        req(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "idle");
        req(16'hFF03, 16'h0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0, "timer_ffff");
        req(16'hFF03, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, "timer_wrap");
        req(16'hFF03, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, "timer_inc");
`else
        req(16'hFF03, 16'hFFFE, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0, "timer_absent_wr");
        req(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "idle");
        req(16'hFF03, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, "timer_absent_rd");
`endif

        // Async reset mid-RUN: leave address 5 presented so stale data would show
        req(16'h0005, 16'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 16'h00A5, "pre_reset");
        #2;
        reset = 1'b0;
        #1;
        check("midrst_led", led_out, 16'h0000);
        check("midrst_ready", {15'd0, mem_ready}, 16'd0);
        check("midrst_data", data_from_mem, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        wait_ready("reboot");
        req(16'h0005, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, "ram_recleared_5");
        req(16'h03FF, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, "ram_recleared_1023");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
